simulador_planta: RTL and testbench
===================================

Name: simulador_planta

Overview:
- Behavioural emulator of the bottling line: the plant side of the controller's sensor/actuator interface.
- Consumes the actuator commands MOTOR, EV and VE.
- Produces the sensor levels PG, CH, RO, CQ and EB that the production state machine expects.
- Used for on-board demo and for closed-loop benches of the controller and its dozen/cork counters.
- Models one bottle on the conveyor at a time, a fill level, and a cork reservoir.

Parameters:
- POS_FILL, 4: conveyor position of the filling station.
- POS_SEAL, 8: conveyor position of the sealing (cork) station.
- POS_END, 12: conveyor position of the quality-check / exit point; must exceed POS_SEAL, which must exceed POS_FILL.
- FILL_TICKS, 6: EV-active ticks needed to fill a bottle; range 1..15.
- ROLHAS_INIT, 10: cork stock after reset or reload; range 0..255.
- REJECT_PERIOD, 5: every Nth bottle fails quality check; 0 disables rejection.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- tick, input, 1: one-cycle plant time-step strobe (divided-clock enable).
- MOTOR, input, 1: conveyor run command.
- EV, input, 1: fill valve command.
- VE, input, 1: sealer command.
- repor_rolhas, input, 1: reload cork stock to ROLHAS_INIT.
- PG, output, 1: bottle present at filling station.
- CH, output, 1: bottle at filling station is full.
- RO, output, 1: cork stock non-empty.
- CQ, output, 1: bottle at exit passed quality check.
- EB, output, 1: bottle present at sealing station.
- garrafas_saida, output, 8: bottles that have left the line; wraps at 255 to 0.
- rolhas_estoque, output, 8: current cork stock.
- erro_derrame, output, 1: sticky; spill or overfill occurred.
- erro_vedacao, output, 1: sticky; invalid seal attempt occurred.

Behaviour:
- Clock and reset
  - One clock. reset is synchronous, active-high, and takes priority over every other input.
  - Reset mid-operation discards the bottle in progress with no garrafas_saida increment.
- Reset state
  - pos=0, nivel=0, vedada=0, indice=0, ve_q=0.
  - rolhas_estoque=ROLHAS_INIT, garrafas_saida=0, both error flags 0.
- Update timing
  - State updates only in cycles where tick=1. repor_rolhas is the exception and acts in any cycle.
  - Every update in a tick cycle uses the pre-update pos.
- Sensor decode
  - Sensors are combinational decodes of registered state; zero latency after a state update.
  - PG = (pos==POS_FILL).
  - EB = (pos==POS_SEAL).
  - CH = PG and (nivel>=FILL_TICKS).
  - RO = (rolhas_estoque!=0).
  - CQ = (pos==POS_END) and (nivel>=FILL_TICKS) and vedada and not rejeito.
  - rejeito = (REJECT_PERIOD!=0) and (indice==REJECT_PERIOD-1).
- Conveyor (tick and MOTOR)
  - If pos<POS_END: pos+1.
  - If pos==POS_END: bottle exits. pos=0, nivel=0, vedada=0, garrafas_saida+1.
  - On exit, indice advances mod REJECT_PERIOD; indice stays 0 when REJECT_PERIOD=0.
  - A new bottle is always present at pos 0.
- Filling (tick and EV)
  - At pos==POS_FILL with nivel<FILL_TICKS: nivel+1.
  - At pos==POS_FILL with nivel>=FILL_TICKS: nivel holds and erro_derrame=1 (overfill).
  - At pos!=POS_FILL: erro_derrame=1 (spill), nivel unchanged.
  - Fill and move in the same tick is legal: fill applies at the old position, then the bottle moves.
- Sealing (tick, VE rising edge)
  - Edge is VE=1 and ve_q=0; ve_q samples VE each tick.
  - Valid edge requires pos==POS_SEAL, vedada=0 and rolhas_estoque>0: vedada=1, rolhas_estoque-1.
  - An edge failing any of those conditions sets erro_vedacao=1 and leaves stock unchanged.
  - VE held high seals at most once.
- Cork reload
  - repor_rolhas sets rolhas_estoque=ROLHAS_INIT.
  - If reload coincides with consumption, reload wins and the consumption is lost; the seal itself still completes.
- Error flags
  - Cleared only by reset.
- Width rules
  - nivel is 4 bits, pos is 4 bits, stock and count are 8 bits. No arithmetic underflow or overflow is possible other than the documented wrap of garrafas_saida.

Test Plan:
- Reset, then MOTOR=1 for 4 ticks -> PG=1, EB=0, CH=0, RO=1, rolhas_estoque=10.
- At POS_FILL, EV=1 for 6 ticks -> CH=1 after the 6th tick. A 7th EV tick -> CH stays 1, erro_derrame=1.
- Full bottle to POS_SEAL, VE pulse -> vedada, rolhas_estoque=9. VE held 3 ticks -> still 9, no error. VE edge at pos 5 -> erro_vedacao=1.
- Full sealed bottle to POS_END -> CQ=1. Next MOTOR tick -> pos=0, garrafas_saida=1, CQ=0.
- Five good bottles -> bottles 1-4 show CQ=1 at exit, bottle 5 shows CQ=0, garrafas_saida=5.
- ROLHAS_INIT=1: seal one bottle -> RO=0. Next VE edge at POS_SEAL -> erro_vedacao=1. Then repor_rolhas during a tick with a valid VE edge -> rolhas_estoque=1, vedada=1.

Source files
------------

// File: rtl/simulador_planta.sv
// Plant-side emulator of the bottling line: turns MOTOR/EV/VE commands into the
// PG/CH/RO/CQ/EB sensor levels for one bottle on the conveyor and a cork reservoir.
module simulador_planta #(
  parameter int POS_FILL      = 4,
  parameter int POS_SEAL      = 8,
  parameter int POS_END       = 12,
  parameter int FILL_TICKS    = 6,
  parameter int ROLHAS_INIT   = 10,
  parameter int REJECT_PERIOD = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       MOTOR,
  input  logic       EV,
  input  logic       VE,
  input  logic       repor_rolhas,
  output logic       PG,
  output logic       CH,
  output logic       RO,
  output logic       CQ,
  output logic       EB,
  output logic [7:0] garrafas_saida,
  output logic [7:0] rolhas_estoque,
  output logic       erro_derrame,
  output logic       erro_vedacao
);

  localparam logic [3:0] POS_FILL_C    = 4'(POS_FILL);
  localparam logic [3:0] POS_SEAL_C    = 4'(POS_SEAL);
  localparam logic [3:0] POS_END_C     = 4'(POS_END);
  localparam logic [3:0] FILL_TICKS_C  = 4'(FILL_TICKS);
  localparam logic [7:0] ROLHAS_INIT_C = 8'(ROLHAS_INIT);
  localparam logic       REJ_EN_C      = (REJECT_PERIOD != 0);
  localparam logic [7:0] REJ_LAST_C    = (REJECT_PERIOD == 0) ? 8'd0 : 8'(REJECT_PERIOD - 1);

  logic [3:0] pos_r;
  logic [3:0] nivel_r;
  logic       vedada_r;
  logic       ve_q_r;
  logic [7:0] indice_r;
  logic [7:0] garrafas_r;
  logic [7:0] rolhas_r;
  logic       erro_derrame_r;
  logic       erro_vedacao_r;

  logic       at_fill_s;
  logic       not_full_s;
  logic       move_s;
  logic       exit_s;
  logic       fill_s;
  logic       spill_s;
  logic       seal_edge_s;
  logic       seal_ok_s;
  logic       rejeito_s;
  logic [7:0] indice_next_s;

  // Per-tick event decode, all from the pre-update state
  always_comb begin
    at_fill_s     = (pos_r == POS_FILL_C);
    not_full_s    = (nivel_r < FILL_TICKS_C);
    move_s        = tick & MOTOR & (pos_r < POS_END_C);
    exit_s        = tick & MOTOR & (pos_r >= POS_END_C);
    fill_s        = tick & EV & at_fill_s & not_full_s;
    spill_s       = tick & EV & ~(at_fill_s & not_full_s);
    seal_edge_s   = tick & VE & ~ve_q_r;
    seal_ok_s     = seal_edge_s & (pos_r == POS_SEAL_C) & ~vedada_r & (rolhas_r != 8'd0);
    rejeito_s     = REJ_EN_C & (indice_r == REJ_LAST_C);
    if (REJ_EN_C && (indice_r != REJ_LAST_C)) begin
      indice_next_s = indice_r + 8'd1;
    end else begin
      indice_next_s = 8'd0;
    end
  end

  // Plant state: conveyor, fill level, seal, cork stock and sticky errors
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_r          <= 4'd0;
      nivel_r        <= 4'd0;
      vedada_r       <= 1'b0;
      ve_q_r         <= 1'b0;
      indice_r       <= 8'd0;
      garrafas_r     <= 8'd0;
      rolhas_r       <= ROLHAS_INIT_C;
      erro_derrame_r <= 1'b0;
      erro_vedacao_r <= 1'b0;
    end else begin
      // Exit replaces the bottle; filling/sealing at the exit point cannot succeed anyway
      if (exit_s) begin
        pos_r      <= 4'd0;
        nivel_r    <= 4'd0;
        vedada_r   <= 1'b0;
        garrafas_r <= garrafas_r + 8'd1;
        indice_r   <= indice_next_s;
      end else begin
        if (move_s) begin
          pos_r <= pos_r + 4'd1;
        end
        if (fill_s) begin
          nivel_r <= nivel_r + 4'd1;
        end
        if (seal_ok_s) begin
          vedada_r <= 1'b1;
        end
      end
      if (tick) begin
        ve_q_r <= VE;
      end
      // Reload beats a simultaneous consumption
      if (repor_rolhas) begin
        rolhas_r <= ROLHAS_INIT_C;
      end else if (seal_ok_s) begin
        rolhas_r <= rolhas_r - 8'd1;
      end
      if (spill_s) begin
        erro_derrame_r <= 1'b1;
      end
      if (seal_edge_s && !seal_ok_s) begin
        erro_vedacao_r <= 1'b1;
      end
    end
  end

  assign PG             = (pos_r == POS_FILL_C);
  assign EB             = (pos_r == POS_SEAL_C);
  assign CH             = PG & (nivel_r >= FILL_TICKS_C);
  assign RO             = (rolhas_r != 8'd0);
  assign CQ             = (pos_r == POS_END_C) & (nivel_r >= FILL_TICKS_C) & vedada_r & ~rejeito_s;
  assign garrafas_saida = garrafas_r;
  assign rolhas_estoque = rolhas_r;
  assign erro_derrame   = erro_derrame_r;
  assign erro_vedacao   = erro_vedacao_r;

endmodule

// File: tb/tb_simulador_planta.sv
// Bench for simulador_planta: two instances (cork stock 10 and 1) driven in lockstep and
// compared every step against a bottle-level reference model, plus directed line scenarios.
module tb_simulador_planta;

  logic clock = 1'b0;
  logic reset, tick, MOTOR, EV, VE, repor_rolhas;
  logic pg0, ch0, ro0, cq0, eb0, ed0, ev0;
  logic pg1, ch1, ro1, cq1, eb1, ed1, ev1;
  logic [7:0] gs0, rs0, gs1, rs1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int pos; int nivel; bit vedada; bit vq; int stock; int exited; bit ederr; bit ever;
  } plant_t;

  plant_t m0, m1;

  always #5 clock = ~clock;

  simulador_planta #(.ROLHAS_INIT(10)) u0 (
    .clock(clock), .reset(reset), .tick(tick), .MOTOR(MOTOR), .EV(EV), .VE(VE),
    .repor_rolhas(repor_rolhas), .PG(pg0), .CH(ch0), .RO(ro0), .CQ(cq0), .EB(eb0),
    .garrafas_saida(gs0), .rolhas_estoque(rs0), .erro_derrame(ed0), .erro_vedacao(ev0));

  simulador_planta #(.ROLHAS_INIT(1)) u1 (
    .clock(clock), .reset(reset), .tick(tick), .MOTOR(MOTOR), .EV(EV), .VE(VE),
    .repor_rolhas(repor_rolhas), .PG(pg1), .CH(ch1), .RO(ro1), .CQ(cq1), .EB(eb1),
    .garrafas_saida(gs1), .rolhas_estoque(rs1), .erro_derrame(ed1), .erro_vedacao(ev1));

  function automatic plant_t plant_init(int rinit);
    plant_t s;
    s.pos = 0; s.nivel = 0; s.vedada = 0; s.vq = 0;
    s.stock = rinit; s.exited = 0; s.ederr = 0; s.ever = 0;
    return s;
  endfunction

  // One plant time-step described at bottle level: fill, seal, then move/exit.
  function automatic plant_t model_step(plant_t s, bit t, bit m, bit e, bit v, bit r, int rinit);
    plant_t n = s;
    if (t) begin
      if (e) begin
        if (s.pos == 4 && s.nivel < 6) n.nivel = s.nivel + 1;
        else n.ederr = 1;
      end
      if (v && !s.vq) begin
        if (s.pos == 8 && !s.vedada && s.stock > 0) begin
          n.vedada = 1; n.stock = s.stock - 1;
        end else n.ever = 1;
      end
      n.vq = v;
      if (m) begin
        if (s.pos < 12) n.pos = s.pos + 1;
        else begin n.pos = 0; n.nivel = 0; n.vedada = 0; n.exited = s.exited + 1; end
      end
    end
    if (r) n.stock = rinit;
    return n;
  endfunction

  // Expected {0,PG,CH,RO,CQ,EB,erro_derrame,erro_vedacao}
  function automatic logic [7:0] sensors(plant_t s);
    bit pg, ch, ro, cq, eb;
    pg = (s.pos == 4);
    eb = (s.pos == 8);
    ch = pg && (s.nivel >= 6);
    ro = (s.stock != 0);
    cq = (s.pos == 12) && (s.nivel >= 6) && s.vedada && ((s.exited % 5) != 4);
    return {1'b0, pg, ch, ro, cq, eb, s.ederr, s.ever};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sens0", {1'b0, pg0, ch0, ro0, cq0, eb0, ed0, ev0}, sensors(m0));
    chk("gar0", gs0, 8'(m0.exited % 256));
    chk("stk0", rs0, 8'(m0.stock));
    chk("sens1", {1'b0, pg1, ch1, ro1, cq1, eb1, ed1, ev1}, sensors(m1));
    chk("gar1", gs1, 8'(m1.exited % 256));
    chk("stk1", rs1, 8'(m1.stock));
  endtask

  task automatic step(input bit rst, input bit t, input bit m, input bit e, input bit v, input bit r);
    reset = rst; tick = t; MOTOR = m; EV = e; VE = v; repor_rolhas = r;
    @(posedge clock);
    if (rst) begin
      m0 = plant_init(10); m1 = plant_init(1);
    end else begin
      m0 = model_step(m0, t, m, e, v, r, 10);
      m1 = model_step(m1, t, m, e, v, r, 1);
    end
    #1;
    check_all();
  endtask

  task automatic move(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0, 0);
  endtask

  // Full bottle from pos 0 through exit, with directed expectations at seal and exit
  task automatic bottle(input bit repor_before, input bit ve_at5, input bit repor_at_seal,
                        input logic [7:0] stk0, input logic [7:0] stk1,
                        input logic cqa, input logic cqb, input logic [7:0] gar);
    if (repor_before) step(0, 0, 0, 0, 0, 1);
    move(4);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, 0);
    chk("ch_full", {7'd0, ch0}, 8'd1);
    if (ve_at5) begin
      move(1);
      step(0, 1, 0, 0, 1, 0);
      chk("ve_pos5", {7'd0, ev0}, 8'd1);
      step(0, 1, 0, 0, 0, 0);
      move(3);
    end else move(4);
    chk("eb_seal", {7'd0, eb0}, 8'd1);
    step(0, 1, 0, 0, 1, repor_at_seal);
    chk("seal_stk0", rs0, stk0);
    chk("seal_stk1", rs1, stk1);
    step(0, 1, 0, 0, 0, 0);
    move(4);
    chk("cq0_end", {7'd0, cq0}, {7'd0, cqa});
    chk("cq1_end", {7'd0, cq1}, {7'd0, cqb});
    move(1);
    chk("gar_exit", gs0, gar);
  endtask

  initial begin
    m0 = plant_init(10); m1 = plant_init(1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    chk("rst_stk", rs0, 8'd10);
    chk("rst_gar", gs0, 8'd0);
    chk("rst_sens", {pg0, ch0, ro0, cq0, eb0, ed0, ev0}, 8'b0010000);

    // Bottle 1: explicit walk through the test scenario
    move(4);
    chk("pg_fill", {pg0, eb0, ch0, ro0}, 8'b1001);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0);
    chk("ch_5", {7'd0, ch0}, 8'd0);
    step(0, 1, 0, 1, 0, 0);
    chk("ch_6", {ch0, ed0}, 8'b10);
    step(0, 1, 0, 1, 0, 0);
    chk("overfill", {ch0, ed0}, 8'b11);
    move(4);
    step(0, 1, 0, 0, 1, 0);
    chk("seal1_stk0", rs0, 8'd9);
    chk("seal1_ro1", {ro1, rs1}, 9'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
    chk("ve_held", {rs0[6:0], ev0}, {7'd9, 1'b0});
    step(0, 1, 0, 0, 0, 0);
    move(4);
    chk("cq_b1", {7'd0, cq0}, 8'd1);
    move(1);
    chk("exit_b1", {gs0[6:0], cq0}, {7'd1, 1'b0});

    bottle(0, 0, 0, 8'd8,  8'd0, 1'b1, 1'b0, 8'd2);
    chk("ro1_err", {ro1, ev1}, 8'b01);
    bottle(1, 1, 1, 8'd10, 8'd1, 1'b1, 1'b1, 8'd3);
    bottle(0, 0, 0, 8'd9,  8'd0, 1'b1, 1'b1, 8'd4);
    bottle(0, 0, 0, 8'd8,  8'd0, 1'b0, 1'b0, 8'd5);

    // Mid-run reset discards the bottle in progress
    move(3);
    step(1, 1, 1, 0, 0, 0);
    chk("midrst", {gs0, pg0}, 9'd0);

    // Randomized closed-loop traffic with occasional resets and reloads
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
    end

    // Counter wrap: 257 exits
    step(1, 0, 0, 0, 0, 0);
    move(257 * 13);
    chk("wrap", gs0, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
